// File: rtl/esp_port_ctrl_if.sv
// Z80 register bus and ESP byte link of esp_port_ctrl.
// The slave modport is the controller side, the master modport is the host/link side.
interface esp_port_ctrl_if;
    logic       bus_addr;
    logic       bus_rd;
    logic       bus_wr;
    logic [7:0] bus_wrdata;
    logic [7:0] bus_rddata;
    logic [7:0] tx_data;
    logic       tx_sof;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output bus_addr, bus_rd, bus_wr, bus_wrdata, tx_ready, rx_data, rx_valid,
        input  bus_rddata, tx_data, tx_sof, tx_valid
    );

    modport slave (
        input  bus_addr, bus_rd, bus_wr, bus_wrdata, tx_ready, rx_data, rx_valid,
        output bus_rddata, tx_data, tx_sof, tx_valid
    );
endinterface

// File: rtl/esp_port_ctrl.sv
// ESP link port controller: STATUS/DATA register pair over an RX byte FIFO and a TX FIFO
// whose entries carry a start-of-frame marker armed by a FRAME_START status write.
module esp_port_ctrl #(
    parameter int unsigned RXDEPTH_LOG2 = 3,
    parameter int unsigned TXDEPTH_LOG2 = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    esp_port_ctrl_if.slave port
);
    localparam int unsigned RxDepth = 1 << RXDEPTH_LOG2;
    localparam int unsigned TxDepth = 1 << TXDEPTH_LOG2;

    typedef logic [RXDEPTH_LOG2-1:0] rx_ptr_t;
    typedef logic [RXDEPTH_LOG2:0]   rx_cnt_t;
    typedef logic [TXDEPTH_LOG2-1:0] tx_ptr_t;
    typedef logic [TXDEPTH_LOG2:0]   tx_cnt_t;

    localparam rx_cnt_t RxFullCnt = rx_cnt_t'(RxDepth);
    localparam tx_cnt_t TxFullCnt = tx_cnt_t'(TxDepth);

    // Bus decode: a write in the same cycle as a read suppresses the read.
    logic rd_eff;
    logic status_rd;
    logic data_rd;
    logic data_wr;
    logic frame_start;

    always_comb begin
        rd_eff      = port.bus_rd & ~port.bus_wr;
        status_rd   = rd_eff & ~port.bus_addr;
        data_rd     = rd_eff & port.bus_addr;
        data_wr     = port.bus_wr & port.bus_addr;
        frame_start = port.bus_wr & ~port.bus_addr & port.bus_wrdata[7];
    end

    // RX FIFO
    logic [7:0] rx_mem_q [RxDepth];
    rx_ptr_t    rx_rd_ptr_q;
    rx_ptr_t    rx_wr_ptr_q;
    rx_cnt_t    rx_cnt_q;
    rx_cnt_t    rx_cnt_d;
    logic       rx_ovf_q;
    logic       rx_ovf_d;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_pop;
    logic       rx_push;
    logic       rx_drop;

    always_comb begin
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == RxFullCnt);
        rx_pop   = data_rd & ~rx_empty;
        // A pop in the same cycle frees the slot the incoming byte needs.
        rx_push  = port.rx_valid & ~frame_start & (~rx_full | rx_pop);
        rx_drop  = port.rx_valid & ~frame_start & rx_full & ~rx_pop;

        rx_cnt_d = rx_cnt_q;
        rx_ovf_d = rx_ovf_q | rx_drop;
        if (frame_start) begin
            rx_cnt_d = '0;
            rx_ovf_d = 1'b0;
        end else if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + rx_cnt_t'(1);
        end else if (rx_pop && !rx_push) begin
            rx_cnt_d = rx_cnt_q - rx_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rx_ovf_q    <= 1'b0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            rx_ovf_q <= rx_ovf_d;
            if (frame_start) begin
                rx_rd_ptr_q <= '0;
                rx_wr_ptr_q <= '0;
            end else begin
                if (rx_push) begin
                    rx_wr_ptr_q <= rx_wr_ptr_q + rx_ptr_t'(1);
                end
                if (rx_pop) begin
                    rx_rd_ptr_q <= rx_rd_ptr_q + rx_ptr_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= port.rx_data;
        end
    end

    // TX FIFO
    logic [7:0]         tx_data_mem_q [TxDepth];
    logic [TxDepth-1:0] tx_sof_mem_q;
    tx_ptr_t            tx_rd_ptr_q;
    tx_ptr_t            tx_wr_ptr_q;
    tx_cnt_t            tx_cnt_q;
    tx_cnt_t            tx_cnt_d;
    logic               tx_ovf_q;
    logic               tx_ovf_d;
    logic               sof_pending_q;
    logic               sof_pending_d;
    logic               tx_nonempty;
    logic               tx_full;
    logic               tx_pop;
    logic               tx_push;
    logic               tx_drop;

    always_comb begin
        tx_nonempty = (tx_cnt_q != '0);
        tx_full     = (tx_cnt_q == TxFullCnt);
        tx_pop      = tx_nonempty & port.tx_ready;
        tx_push     = data_wr & (~tx_full | tx_pop);
        tx_drop     = data_wr & tx_full & ~tx_pop;

        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + tx_cnt_t'(1);
        end else if (tx_pop && !tx_push) begin
            tx_cnt_d = tx_cnt_q - tx_cnt_t'(1);
        end

        // FRAME_START leaves TX contents alone but re-arms the marker for the next push.
        tx_ovf_d      = frame_start ? 1'b0 : (tx_ovf_q | tx_drop);
        sof_pending_d = sof_pending_q;
        if (frame_start) begin
            sof_pending_d = 1'b1;
        end else if (tx_push) begin
            sof_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_rd_ptr_q   <= '0;
            tx_wr_ptr_q   <= '0;
            tx_cnt_q      <= '0;
            tx_ovf_q      <= 1'b0;
            sof_pending_q <= 1'b0;
            tx_sof_mem_q  <= '0;
        end else begin
            tx_cnt_q      <= tx_cnt_d;
            tx_ovf_q      <= tx_ovf_d;
            sof_pending_q <= sof_pending_d;
            if (tx_push) begin
                tx_wr_ptr_q               <= tx_wr_ptr_q + tx_ptr_t'(1);
                tx_sof_mem_q[tx_wr_ptr_q] <= sof_pending_q;
            end
            if (tx_pop) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + tx_ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_data_mem_q[tx_wr_ptr_q] <= port.bus_wrdata;
        end
    end

    // Registered read data, held between reads.
    logic [7:0] rddata_q;
    logic [7:0] rddata_d;

    always_comb begin
        rddata_d = rddata_q;
        if (status_rd) begin
            rddata_d = {4'b0000, tx_ovf_q, rx_ovf_q, tx_full, ~rx_empty};
        end else if (data_rd) begin
            rddata_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rddata_q <= 8'h00;
        end else begin
            rddata_q <= rddata_d;
        end
    end

    assign port.bus_rddata = rddata_q;
    assign port.tx_valid   = tx_nonempty;
    assign port.tx_data    = tx_nonempty ? tx_data_mem_q[tx_rd_ptr_q] : 8'h00;
    assign port.tx_sof     = tx_nonempty & tx_sof_mem_q[tx_rd_ptr_q];

endmodule

// File: tb/tb_esp_port_ctrl.sv
// Bench for esp_port_ctrl: directed scenarios plus randomized traffic, all checked against
// a queue-based reference model of the port's register and FIFO behaviour.
module tb_esp_port_ctrl;
    localparam int RxDepth = 8;
    localparam int TxDepth = 8;

    logic clk;
    logic reset_n;

    esp_port_ctrl_if port_if ();

    esp_port_ctrl #(
        .RXDEPTH_LOG2(3),
        .TXDEPTH_LOG2(3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .port   (port_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors;
    int n_miscompares;

    // Reference model state.
    logic [7:0] m_rx [$];
    logic [8:0] m_tx [$];
    logic       m_rx_ovf;
    logic       m_tx_ovf;
    logic       m_sofp;
    logic [7:0] m_rd;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        m_rx_ovf = 1'b0;
        m_tx_ovf = 1'b0;
        m_sofp   = 1'b0;
        m_rd     = 8'h00;
    endtask

    // Applies the inputs currently driven to the model, as the DUT will see them at the edge.
    task automatic model_step();
        logic w;
        logic r;
        logic fs;
        w  = port_if.bus_wr;
        r  = port_if.bus_rd & ~port_if.bus_wr;
        fs = w & ~port_if.bus_addr & port_if.bus_wrdata[7];
        if (r) begin
            if (!port_if.bus_addr) begin
                m_rd = {4'h0, m_tx_ovf, m_rx_ovf, m_tx.size() == TxDepth, m_rx.size() != 0};
            end else if (m_rx.size() > 0) begin
                m_rd = m_rx.pop_front();
            end else begin
                m_rd = 8'h00;
            end
        end
        if (fs) begin
            m_rx.delete();
            m_rx_ovf = 1'b0;
            m_tx_ovf = 1'b0;
            m_sofp   = 1'b1;
        end else if (port_if.rx_valid) begin
            if (m_rx.size() < RxDepth) m_rx.push_back(port_if.rx_data);
            else m_rx_ovf = 1'b1;
        end
        if (port_if.tx_ready && m_tx.size() > 0) void'(m_tx.pop_front());
        if (w && port_if.bus_addr) begin
            if (m_tx.size() < TxDepth) begin
                m_tx.push_back({m_sofp, port_if.bus_wrdata});
                m_sofp = 1'b0;
            end else begin
                m_tx_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("rddata", port_if.bus_rddata, m_rd);
        check("tx_valid", port_if.tx_valid, m_tx.size() != 0);
        if (m_tx.size() != 0) begin
            check("tx_data", port_if.tx_data, m_tx[0][7:0]);
            check("tx_sof", port_if.tx_sof, m_tx[0][8]);
        end
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        port_if.bus_addr   = a;
        port_if.bus_wrdata = d;
        port_if.bus_wr     = 1'b1;
        cycle();
        port_if.bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic a);
        port_if.bus_addr = a;
        port_if.bus_rd   = 1'b1;
        cycle();
        port_if.bus_rd = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        port_if.rx_data  = d;
        port_if.rx_valid = 1'b1;
        cycle();
        port_if.rx_valid = 1'b0;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        model_reset();
        reset_n            = 1'b0;
        port_if.bus_addr   = 1'b0;
        port_if.bus_rd     = 1'b0;
        port_if.bus_wr     = 1'b0;
        port_if.bus_wrdata = 8'h00;
        port_if.tx_ready   = 1'b0;
        port_if.rx_data    = 8'h00;
        port_if.rx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rddata", port_if.bus_rddata, 8'h00);
        check("rst_tx_valid", port_if.tx_valid, 1'b0);
        check("rst_tx_sof", port_if.tx_sof, 1'b0);
        reset_n = 1'b1;
        bus_read(1'b0);
        check("rst_status", port_if.bus_rddata, 8'h00);

        // Frame start marks only the first byte.
        port_if.tx_ready = 1'b1;
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h10);
        check("fs_first_data", port_if.tx_data, 8'h10);
        check("fs_first_sof", port_if.tx_sof, 1'b1);
        bus_write(1'b1, 8'h41);
        check("fs_second_data", port_if.tx_data, 8'h41);
        check("fs_second_sof", port_if.tx_sof, 1'b0);
        cycle();
        check("fs_drained", port_if.tx_valid, 1'b0);

        // RX drain.
        rx_byte(8'h3E);
        rx_byte(8'h33);
        bus_read(1'b0);
        check("drain_status1", port_if.bus_rddata, 8'h01);
        bus_read(1'b1);
        check("drain_data1", port_if.bus_rddata, 8'h3E);
        bus_read(1'b1);
        check("drain_data2", port_if.bus_rddata, 8'h33);
        bus_read(1'b0);
        check("drain_status2", port_if.bus_rddata, 8'h00);
        bus_read(1'b1);
        check("drain_empty_data", port_if.bus_rddata, 8'h00);

        // RX overflow.
        for (int i = 0; i < 9; i++) rx_byte(8'(8'h60 + i));
        bus_read(1'b0);
        check("rxovf_status", port_if.bus_rddata, 8'h05);
        for (int i = 0; i < 8; i++) begin
            bus_read(1'b1);
            check("rxovf_data", port_if.bus_rddata, 8'(8'h60 + i));
        end
        bus_write(1'b0, 8'h80);
        bus_read(1'b0);
        check("rxovf_cleared", port_if.bus_rddata, 8'h00);

        // TX backpressure.
        port_if.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus_write(1'b1, 8'(8'hA0 + i));
        bus_read(1'b0);
        check("txbp_status", port_if.bus_rddata, 8'h0A);
        port_if.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("txbp_valid", port_if.tx_valid, 1'b1);
            check("txbp_data", port_if.tx_data, 8'(8'hA0 + i));
            cycle();
        end
        check("txbp_empty", port_if.tx_valid, 1'b0);

        // Simultaneous push/pop on a full RX FIFO, then FRAME_START against rx_valid.
        bus_write(1'b0, 8'h80);
        for (int i = 0; i < 8; i++) rx_byte(8'(8'hC0 + i));
        port_if.rx_data  = 8'hC8;
        port_if.rx_valid = 1'b1;
        bus_read(1'b1);
        port_if.rx_valid = 1'b0;
        check("simul_pop_data", port_if.bus_rddata, 8'hC0);
        bus_read(1'b0);
        check("simul_status", port_if.bus_rddata, 8'h01);
        rx_byte(8'hEE);
        bus_read(1'b0);
        check("simul_still_full", port_if.bus_rddata, 8'h05);
        port_if.rx_data  = 8'h77;
        port_if.rx_valid = 1'b1;
        bus_write(1'b0, 8'h80);
        port_if.rx_valid = 1'b0;
        bus_read(1'b0);
        check("fs_beats_rx", port_if.bus_rddata, 8'h00);

        // Mid-operation reset with both FIFOs half full.
        port_if.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) rx_byte(8'(8'h20 + i));
        for (int i = 0; i < 4; i++) bus_write(1'b1, 8'(8'h30 + i));
        check("pre_rst_valid", port_if.tx_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", port_if.tx_valid, 1'b0);
        check("async_rst_sof", port_if.tx_sof, 1'b0);
        check("async_rst_rddata", port_if.bus_rddata, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_read(1'b0);
        check("post_rst_status", port_if.bus_rddata, 8'h00);

        // Randomized traffic with per-block rates.
        for (int blk = 0; blk < 8; blk++) begin
            int unsigned p_wr;
            int unsigned p_rd;
            int unsigned p_rx;
            int unsigned p_rdy;
            p_wr  = $urandom_range(60, 5);
            p_rd  = $urandom_range(70, 5);
            p_rx  = $urandom_range(80, 5);
            p_rdy = $urandom_range(90, 5);
            for (int n = 0; n < 250; n++) begin
                port_if.bus_wr     = ($urandom_range(99) < p_wr);
                port_if.bus_rd     = ($urandom_range(99) < p_rd);
                port_if.bus_addr   = ($urandom_range(3) != 0);
                port_if.bus_wrdata = 8'($urandom);
                port_if.rx_valid   = ($urandom_range(99) < p_rx);
                port_if.rx_data    = 8'($urandom);
                port_if.tx_ready   = ($urandom_range(99) < p_rdy);
                cycle();
            end
        end
        port_if.bus_wr   = 1'b0;
        port_if.bus_rd   = 1'b0;
        port_if.rx_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/esp_port_ctrl.md
ESP_PORT_CTRL -- requirements
Module: esp_port_ctrl

Interface
REQ-001 SHALL have parameter RXDEPTH_LOG2, default 3: RX FIFO depth is 2^RXDEPTH_LOG2 bytes.
REQ-002 SHALL have parameter TXDEPTH_LOG2, default 3: TX FIFO depth is 2^TXDEPTH_LOG2 entries (8-bit data plus 1-bit SOF).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk in 1, system clock, all state on rising edge; reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have bus_addr in 1: register select, 0 = STATUS (Z80 port F4h), 1 = DATA (port F5h).
REQ-005 SHALL have bus_rd in 1: single-cycle read strobe.
REQ-006 SHALL have bus_wr in 1: single-cycle write strobe.
REQ-007 SHALL have bus_wrdata in 8: write data.
REQ-008 SHALL have bus_rddata out 8: registered read data.
REQ-009 SHALL have tx_data out 8: byte to ESP link.
REQ-010 SHALL have tx_sof out 1: tx_data is the first byte of a command frame.
REQ-011 SHALL have tx_valid out 1: TX head valid.
REQ-012 SHALL have tx_ready in 1: link accepts the head byte.
REQ-013 SHALL have rx_data in 8: byte from ESP link.
REQ-014 SHALL have rx_valid in 1: single-cycle push of rx_data, no backpressure.

Function
REQ-015 SHALL define STATUS read value as {4'b0, tx_ovf, rx_ovf, tx_full, rx_nonempty} (bit0 = rx_nonempty).
REQ-016 SHALL return the addressed value on bus_rddata on the clock edge after bus_rd (1-cycle latency) and hold it until the next bus_rd.
REQ-017 SHALL pop the RX FIFO on a DATA read when it is non-empty and return the head byte.
REQ-018 SHALL return 00h on a DATA read of an empty RX FIFO, with no pop and no flag change.
REQ-019 SHALL push bus_wrdata to the TX FIFO on a DATA write when the FIFO is not full.
REQ-020 SHALL drop a DATA write when the TX FIFO is full, set tx_ovf, and leave the FIFO unchanged.
REQ-021 SHALL, on a STATUS write with bus_wrdata[7]=1 (FRAME_START), flush the RX FIFO, clear rx_ovf and tx_ovf, and arm sof_pending.
REQ-022 SHALL ignore STATUS writes with bus_wrdata[7]=0.
REQ-023 SHALL leave the TX FIFO contents untouched on FRAME_START.
REQ-024 SHALL store the SOF bit of a pushed TX entry as sof_pending, and clear sof_pending on that push.
REQ-025 SHALL drive tx_valid = TX non-empty and tx_data/tx_sof from the TX head.
REQ-026 SHALL pop the TX FIFO in any cycle where tx_valid and tx_ready are both 1.
REQ-027 SHALL not change tx_data/tx_sof while tx_valid=1 and tx_ready=0.
REQ-028 SHALL push rx_data on rx_valid when the RX FIFO is not full.
REQ-029 SHALL drop rx_data on rx_valid when the RX FIFO is full with no simultaneous pop, and set rx_ovf (sticky).
REQ-030 SHALL, when RX is full and rx_valid coincides with a DATA-read pop, perform both operations: count unchanged, no overflow.
REQ-031 SHALL, when TX is full and a DATA write coincides with a TX pop, accept the write.
REQ-032 SHALL give FRAME_START priority over a simultaneous rx_valid: the incoming byte is discarded and rx_ovf stays 0.
REQ-033 SHALL update flags the cycle after the causing event and reflect them in the next STATUS read.
REQ-034 SHALL implement FIFO pointers modulo depth with an explicit count of RXDEPTH_LOG2+1 and TXDEPTH_LOG2+1 bits; full = count==depth.
REQ-035 SHALL treat simultaneous bus_rd and bus_wr as the write only, with bus_rddata held.

Reset
REQ-036 SHALL, while reset_n=0 (asynchronous assert), empty both FIFOs and clear rx_ovf, tx_ovf, sof_pending, bus_rddata=00h, tx_valid=0, tx_sof=0.
REQ-037 SHALL discard in-flight FIFO contents on reset asserted mid-transfer, with no partial pop.
REQ-038 SHALL begin operating on the first clock edge after reset_n deasserts.

Verification
REQ-039 SHALL verify frame start: write STATUS 80h, DATA 10h, DATA 41h, with tx_ready=1 -> tx_data 10h with tx_sof=1, then 41h with tx_sof=0.
REQ-040 SHALL verify RX drain: push 3Eh, 33h; read STATUS -> 01h; read DATA x2 -> 3Eh, 33h; read STATUS -> 00h; read DATA -> 00h.
REQ-041 SHALL verify RX overflow: push 9 bytes with depth 8 -> STATUS 05h, and DATA reads return the first 8 bytes; then write STATUS 80h -> STATUS 00h.
REQ-042 SHALL verify TX backpressure: tx_ready=0, write 9 bytes -> STATUS 0Ah; raise tx_ready -> 8 bytes emitted in order, 1 per cycle.
REQ-043 SHALL verify the simultaneous case: RX full, rx_valid together with a DATA read -> count stays 8 and rx_ovf=0; FRAME_START together with rx_valid -> RX empty and rx_ovf=0.
REQ-044 SHALL verify mid-operation reset: assert reset_n=0 with both FIFOs half full -> tx_valid=0 immediately, and STATUS reads 00h after release.
